// File: rtl/crc_stream_gen.sv
// Streaming CRC generator: passes framed data words through, then appends
// the frame CRC as CRC_W/DATA_W trailing words, MSB word first.
module crc_stream_gen #(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready
);

    localparam int NWORDS = CRC_W / DATA_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    if (CRC_W % DATA_W != 0) begin : gBadWidth
        $error("crc_stream_gen: CRC_W must be an integer multiple of DATA_W");
    end

    typedef enum logic {
        S_DATA,
        S_APPEND
    } state_t;

    // Bit-serial MSB-first CRC update, unrolled so one whole word folds in per cycle.
    function automatic logic [CRC_W-1:0] nextCrc(input logic [CRC_W-1:0] crcIn,
                                                  input logic [DATA_W-1:0] dataIn);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crcIn;
        for (int b = DATA_W - 1; b >= 0; b--) begin
            fb = c[CRC_W-1] ^ dataIn[b];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CRC_W-1:0]    finalCrc_q, finalCrc_d;
    logic [CNT_W-1:0]    wordCnt_q, wordCnt_d;
    logic [DATA_W-1:0]   oData_q, oData_d;
    logic                oValid_q, oValid_d;
    logic                oLast_q, oLast_d;

    logic                free;
    logic                inXfer;
    logic [CRC_W-1:0]    crcStep;
    logic [CRC_W-1:0]    crcShifted;
    logic [DATA_W-1:0]   crcWord;

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        finalCrc_d = finalCrc_q;
        wordCnt_d  = wordCnt_q;
        oData_d    = oData_q;
        oValid_d   = oValid_q;
        oLast_d    = oLast_q;
        o_ready    = 1'b0;
        inXfer     = 1'b0;

        free       = ~oValid_q | i_ready;
        crcStep    = nextCrc(crc_q, i_data);
        crcShifted = finalCrc_q << (int'(wordCnt_q) * DATA_W);
        crcWord    = crcShifted[CRC_W-1 -: DATA_W];

        case (state_q)
            S_DATA: begin
                o_ready = free & ~i_rst;
                inXfer  = i_valid & o_ready;
                if (inXfer) begin
                    oData_d  = i_data;
                    oValid_d = 1'b1;
                    oLast_d  = 1'b0;
                    crc_d    = crcStep;
                    if (i_last) begin
                        state_d    = S_APPEND;
                        wordCnt_d  = '0;
                        finalCrc_d = crcStep ^ XOR_OUT;
                    end
                end else if (free) begin
                    oValid_d = 1'b0;
                end
            end
            S_APPEND: begin
                // Counter and current CRC word hold whenever downstream stalls.
                if (free) begin
                    oData_d  = crcWord;
                    oValid_d = 1'b1;
                    oLast_d  = (wordCnt_q == LAST_CNT);
                    if (wordCnt_q == LAST_CNT) begin
                        state_d   = S_DATA;
                        crc_d     = INIT;
                        wordCnt_d = '0;
                    end else begin
                        wordCnt_d = wordCnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_DATA;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_DATA;
            crc_q      <= INIT;
            finalCrc_q <= '0;
            wordCnt_q  <= '0;
            oData_q    <= '0;
            oValid_q   <= 1'b0;
            oLast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            finalCrc_q <= finalCrc_d;
            wordCnt_q  <= wordCnt_d;
            oData_q    <= oData_d;
            oValid_q   <= oValid_d;
            oLast_q    <= oLast_d;
        end
    end

    assign o_data  = oData_q;
    assign o_valid = oValid_q;
    assign o_last  = oLast_q;

endmodule

// File: tb/tb_crc_stream_gen.sv
// Directed bench for crc_stream_gen: default instance plus an XOR_OUT=FFFF
// instance sharing the same input stream, checked against hand-computed CRCs.
module tb_crc_stream_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iValid = 1'b0;
    logic       iLast = 1'b0;
    logic       iReady = 1'b1;

    logic       oReady, oValid, oLast;
    logic [7:0] oData;
    logic       oReady2, oValid2, oLast2;
    logic [7:0] oData2;

    int nChecks = 0;
    int nFails  = 0;

    logic [8:0] outQ[$];
    logic [8:0] out2Q[$];
    logic [8:0] expQ[$];
    logic [8:0] exp2Q[$];
    logic [7:0] stimData[$];
    bit         stimLast[$];

    logic       prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic       prevLast = 1'b0;

    crc_stream_gen dut (
        .i_clk(clk), .i_rst(rst), .i_data(iData), .i_valid(iValid), .i_last(iLast),
        .o_ready(oReady), .o_data(oData), .o_valid(oValid), .o_last(oLast), .i_ready(iReady)
    );

    crc_stream_gen #(.XOR_OUT(16'hFFFF)) dutXor (
        .i_clk(clk), .i_rst(rst), .i_data(iData), .i_valid(iValid), .i_last(iLast),
        .o_ready(oReady2), .o_data(oData2), .o_valid(oValid2), .o_last(oLast2), .i_ready(iReady)
    );

    always #5 clk = ~clk;

    // Record every output transfer and check the output register holds while stalled.
    always @(negedge clk) begin
        if (prevStall) begin
            nChecks++;
            assert (oValid === 1'b1 && oData === prevData && oLast === prevLast)
            else begin
                nFails++;
                $error("[TB] FAIL hold_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                       oValid, oData, oLast, prevData, prevLast);
            end
        end
        if (oValid === 1'b1 && iReady === 1'b1) outQ.push_back({oLast, oData});
        if (oValid2 === 1'b1 && iReady === 1'b1) out2Q.push_back({oLast2, oData2});
        prevStall = oValid && !iReady && !rst;
        prevData  = oData;
        prevLast  = oLast;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        assert (got === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkStream(input string tag, input bit useXor);
        int n;
        n = useXor ? out2Q.size() : outQ.size();
        checkOutput({tag, "_len"}, n, useXor ? exp2Q.size() : expQ.size());
        for (int i = 0; i < n && i < (useXor ? exp2Q.size() : expQ.size()); i++) begin
            if (useXor) checkOutput($sformatf("%s_w%0d", tag, i), {23'd0, out2Q[i]}, {23'd0, exp2Q[i]});
            else        checkOutput($sformatf("%s_w%0d", tag, i), {23'd0, outQ[i]},  {23'd0, expQ[i]});
        end
    endtask

    task automatic addStim(input int n, input bit withLast);
        for (int i = 0; i < n; i++) begin
            stimData.push_back(8'h31 + 8'(i));
            stimLast.push_back(withLast && (i == n - 1));
        end
    endtask

    task automatic addExpected(input int n, input logic [15:0] crc, input logic [15:0] crcXor);
        for (int i = 0; i < n; i++) begin
            expQ.push_back({1'b0, 8'h31 + 8'(i)});
            exp2Q.push_back({1'b0, 8'h31 + 8'(i)});
        end
        expQ.push_back({1'b0, crc[15:8]});
        expQ.push_back({1'b1, crc[7:0]});
        exp2Q.push_back({1'b0, crcXor[15:8]});
        exp2Q.push_back({1'b1, crcXor[7:0]});
    endtask

    task automatic clearAll();
        outQ.delete();
        out2Q.delete();
        expQ.delete();
        exp2Q.delete();
        stimData.delete();
        stimLast.delete();
    endtask

    // Drive the stimulus queue until the expected number of output words has been seen.
    task automatic applyStimulus(input string tag, input bit gaps, input bit toggle, input int target);
        int idx = 0;
        int cyc = 0;
        while (outQ.size() < target && cyc < 2000) begin
            @(posedge clk); #1;
            if (idx < stimData.size()) begin
                iValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                iData  = stimData[idx];
                iLast  = stimLast[idx];
            end else begin
                iValid = 1'b0;
                iLast  = 1'b0;
                iData  = 8'h00;
            end
            iReady = toggle ? ~iReady : 1'b1;
            @(negedge clk); #1;
            if (iValid && oReady) idx++;
            cyc++;
        end
        iValid = 1'b0;
        iLast  = 1'b0;
        checkOutput({tag, "_done"}, (outQ.size() >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        // Power-on reset.
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_ready", oReady, 0);
        @(posedge clk); #1;
        checkOutput("rst_valid", oValid, 0);
        checkOutput("rst_last", oLast, 0);
        checkOutput("rst_data", oData, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", oReady, 1);

        // Reference frame "123456789", CRC 0x29B1 (0xD64E with XOR_OUT).
        $display("[TB] frame 123456789");
        clearAll();
        addStim(9, 1'b1);
        addExpected(9, 16'h29B1, 16'hD64E);
        applyStimulus("f1", 1'b0, 1'b0, 11);
        checkStream("f1", 1'b0);
        checkStream("f1x", 1'b1);
        @(posedge clk); #1;

        // Two frames back-to-back: CRC must restart from INIT.
        $display("[TB] back-to-back frames");
        clearAll();
        addStim(9, 1'b1);
        addStim(9, 1'b1);
        addExpected(9, 16'h29B1, 16'hD64E);
        addExpected(9, 16'h29B1, 16'hD64E);
        applyStimulus("b2b", 1'b0, 1'b0, 22);
        checkStream("b2b", 1'b0);
        checkStream("b2bx", 1'b1);
        @(posedge clk); #1;

        // Toggling backpressure with random input gaps.
        $display("[TB] backpressure and gaps");
        clearAll();
        addStim(9, 1'b1);
        addExpected(9, 16'h29B1, 16'hD64E);
        applyStimulus("bp", 1'b1, 1'b1, 11);
        @(posedge clk); #1;
        iReady = 1'b1;
        checkStream("bp", 1'b0);
        checkStream("bpx", 1'b1);

        // Single-word frame "1": CRC 0xC782.
        $display("[TB] single-word frame");
        clearAll();
        addStim(1, 1'b1);
        addExpected(1, 16'hC782, 16'h387D);
        applyStimulus("one", 1'b0, 1'b0, 3);
        checkStream("one", 1'b0);
        checkStream("onex", 1'b1);
        @(posedge clk); #1;

        // Reset after four words of a frame, then a full frame.
        $display("[TB] reset mid-frame");
        clearAll();
        addStim(4, 1'b0);
        applyStimulus("part", 1'b0, 1'b0, 4);
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", oReady, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_valid", oValid, 0);
        checkOutput("midrst_ready_after", oReady, 1);
        clearAll();
        addStim(9, 1'b1);
        addExpected(9, 16'h29B1, 16'hD64E);
        applyStimulus("after", 1'b0, 1'b0, 11);
        checkStream("after", 1'b0);
        checkStream("afterx", 1'b1);
        @(posedge clk); #1;

        // Reset during append right after the first CRC word.
        $display("[TB] reset during append");
        clearAll();
        addStim(9, 1'b0);
        stimLast[8] = 1'b1;
        for (int i = 0; i < 9; i++) expQ.push_back({1'b0, 8'h31 + 8'(i)});
        expQ.push_back({1'b0, 8'h29});
        applyStimulus("app", 1'b0, 1'b0, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("apprst_valid", oValid, 0);
        checkOutput("apprst_last", oLast, 0);
        checkOutput("apprst_ready", oReady, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("apprst_idle%0d", i), {oValid, oLast}, 0);
        end
        checkStream("app", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/crc_stream_gen.md
Name: crc_stream_gen

Overview:
Parametrised, streaming, sequential CRC generator. It is the successor to the fixed 3-bit combinational encoder, generalised in data width, polynomial, init value and output XOR. It accepts a framed word stream, passes each word through, and appends the frame CRC as CRC_W/DATA_W trailing words. It sits between a frame source and the line/serialiser, with valid/ready flow control on both sides.

Parameters:
DATA_W, 8, width of the data word; CRC_W must be an integer multiple of DATA_W
CRC_W, 16, CRC register width
POLY, 16'h1021, generator polynomial with the implicit x^CRC_W term omitted
INIT, 16'hFFFF, CRC register value at start of each frame
XOR_OUT, 16'h0000, value XORed onto the final CRC before emission

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_data  input  DATA_W  input word
i_valid  input  1  input word valid
i_last  input  1  marks the final data word of a frame; qualified by i_valid
o_ready  output  1  block can accept an input word this cycle
o_data  output  DATA_W  output word (data pass-through or CRC word)
o_valid  output  1  output word valid
o_last  output  1  final word of the output frame (last CRC word only)
i_ready  input  1  downstream accepts an output word this cycle

Behaviour:
- Reset (i_rst=1 at a clock edge): state=S_DATA, crc_reg=INIT, o_valid=0, o_last=0, o_data=0, CRC word counter=0. Reset wins over all other events, including mid-frame and mid-append; a partial frame is discarded with no CRC emitted. o_ready is 0 while i_rst=1.
- Handshakes: input transfer = i_valid & o_ready; output transfer = o_valid & i_ready. o_valid, o_data and o_last stay stable while o_valid=1 and i_ready=0.
- Output stage: a single register. free = ~o_valid | i_ready.
- FSM states:
  - S_DATA: o_ready = free. On an input transfer, o_data<=i_data, o_valid<=1, o_last<=0, and crc_reg<=next_crc(crc_reg, i_data). If i_last=1, go to S_APPEND with counter=0 and latch final=next_crc ^ XOR_OUT. If free=1 and there is no input transfer, o_valid<=0.
  - S_APPEND: o_ready=0. While free=1, emit final[CRC_W-1-k*DATA_W -: DATA_W] for k=counter, MSB word first, with o_valid<=1. o_last<=1 only for k=CRC_W/DATA_W-1. Then return to S_DATA with crc_reg=INIT.
- next_crc: processes data bits MSB first. For each bit: fb = crc[CRC_W-1] ^ bit; crc = (crc<<1) ^ (fb ? POLY : 0). No input or output reflection. It is purely combinational within one cycle, so there is one cycle per word.
- Latency: 1 cycle from input accept to o_valid for data words. The first CRC word appears in the cycle after the last data word is accepted, if downstream is free. A frame of N words produces N + CRC_W/DATA_W output words.
- Throughput: 1 word/cycle during data. The input stalls for CRC_W/DATA_W cycles per frame during append.
- Single-word frame (i_valid & i_last on the first word) is legal and yields 1 data word plus the CRC words.
- Back-to-back frames: the first word of the next frame is accepted in the cycle after the last CRC word's output register load, if free. No bubble is required beyond the append stall.
- Backpressure in S_APPEND holds the counter and current CRC word.
- Elaboration check: if CRC_W % DATA_W != 0, raise an error.

Test Plan:
- Default params, frame ASCII "123456789" (0x31..0x39), i_last on 0x39, i_ready=1 -> output 0x31..0x39, then 0x29, 0xB1 with o_last only on 0xB1. Total 11 words, each 1 cycle after input.
- Same frame sent twice back-to-back -> both frames end with 0x29, 0xB1. Confirms the CRC reinitialises to INIT between frames.
- Same frame with i_ready toggled 1/0 every cycle and random i_valid gaps -> identical output word sequence, no drops or duplicates, o_data stable while stalled.
- Assert i_rst for 1 cycle after 4 words of a frame, then send "123456789" -> o_valid=0 the cycle after reset, no CRC for the partial frame, next frame ends 0x29, 0xB1.
- XOR_OUT=16'hFFFF, same frame -> CRC words 0xD6, 0x4E.
- Assert i_rst during S_APPEND after the first CRC word -> second CRC word never emitted, o_last never asserted, o_ready=1 in the cycle after reset.
